// File: rtl/ws2812b_pkg.sv
// Shared definitions for the WS2812B frame buffer: state encoding and GRB pixel layout.
package ws2812b_pkg;

    localparam int PIXEL_W = 24;
    localparam int CHAN_W  = 8;
    localparam int G_LSB   = 16;
    localparam int R_LSB   = 8;
    localparam int B_LSB   = 0;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_SENDING = 2'b01;
    localparam logic [1:0] ST_LATCH   = 2'b10;

    typedef logic [PIXEL_W-1:0] pixel_t;

    function automatic pixel_t pack_grb(input logic [CHAN_W-1:0] red,
                                        input logic [CHAN_W-1:0] green,
                                        input logic [CHAN_W-1:0] blue);
        return {green, red, blue};
    endfunction

endpackage

// File: rtl/ws2812b_pixel_bank.sv
// One register bank of GRB pixels with a single write port and a combinational read port.
module ws2812b_pixel_bank
    import ws2812b_pkg::*;
#(
    parameter int MAX_POS = 16,
    localparam int ADDR_W = $clog2(MAX_POS)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  pixel_t            wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output pixel_t            rdata_o
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MAX_POS);

    pixel_t mem_q [MAX_POS];
    logic   waddrOk;
    logic   raddrOk;

    assign waddrOk = {1'b0, waddr_i} < DEPTH;
    assign raddrOk = {1'b0, raddr_i} < DEPTH;

    // Out-of-range writes complete upstream but are simply dropped here.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < MAX_POS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && waddrOk) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (raddrOk) begin
            rdata_o = mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/ws2812b_frame_buffer.sv
// Double-buffered pixel store and frame sequencer feeding the WS2812B driver.
// The host fills the back bank and commits; banks swap only while idle between frames.
module ws2812b_frame_buffer
    import ws2812b_pkg::*;
#(
    parameter int MAX_POS      = 16,
    parameter int REFRESH_CLKS = 50000,
    parameter int LATCH_CLKS   = 2700,
    parameter int SEND_TIMEOUT = MAX_POS*24*64+256,
    localparam int ADDR_W = $clog2(MAX_POS)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [7:0]        wr_red_i,
    input  logic [7:0]        wr_green_i,
    input  logic [7:0]        wr_blue_i,
    input  logic              commit_i,
    output logic              commit_pending_o,
    output logic              update_frame_o,
    input  logic [ADDR_W-1:0] program_led_number_i,
    output logic [7:0]        program_red_intensity_o,
    output logic [7:0]        program_green_intensity_o,
    output logic [7:0]        program_blue_intensity_o,
    output logic              frame_done_o,
    output logic              frame_error_o
);

    localparam bit REFRESH_EN = (REFRESH_CLKS != 0);
    localparam int REF_W = $clog2(REFRESH_CLKS > 1 ? REFRESH_CLKS : 2) + 1;
    localparam int WD_W  = $clog2(SEND_TIMEOUT > 1 ? SEND_TIMEOUT : 2) + 1;
    localparam int LAT_W = $clog2(LATCH_CLKS > 1 ? LATCH_CLKS : 2) + 1;

    localparam logic [REF_W-1:0]  REFRESH_LAST = REF_W'(REFRESH_CLKS > 0 ? REFRESH_CLKS - 1 : 0);
    localparam logic [WD_W-1:0]   WD_LAST      = WD_W'(SEND_TIMEOUT > 0 ? SEND_TIMEOUT - 1 : 0);
    localparam logic [LAT_W-1:0]  LATCH_LAST   = LAT_W'(LATCH_CLKS > 0 ? LATCH_CLKS - 1 : 0);
    localparam logic [ADDR_W-1:0] LAST_POS     = ADDR_W'(MAX_POS - 1);

    logic [1:0]        state_q, state_d;
    logic              bankSel_q, bankSel_d;
    logic              commitPending_q, commitPending_d;
    logic              updateFrame_q, updateFrame_d;
    logic              frameDone_q, frameDone_d;
    logic              frameError_q, frameError_d;
    logic [REF_W-1:0]  refreshCnt_q, refreshCnt_d;
    logic [WD_W-1:0]   wdCnt_q, wdCnt_d;
    logic [LAT_W-1:0]  latchCnt_q, latchCnt_d;
    logic [ADDR_W-1:0] prevLed_q, prevLed_d;

    logic   writeAccept;
    logic   wrap;
    pixel_t wrPixel;
    pixel_t bank0Rd;
    pixel_t bank1Rd;
    pixel_t frontRd;

    assign wr_ready_o       = !commitPending_q;
    assign commit_pending_o = commitPending_q;
    assign update_frame_o   = updateFrame_q;
    assign frame_done_o     = frameDone_q;
    assign frame_error_o    = frameError_q;

    assign writeAccept = wr_valid_i && !commitPending_q;
    assign wrPixel     = pack_grb(wr_red_i, wr_green_i, wr_blue_i);

    // Only the back bank (the one not selected by bankSel_q) ever sees a write enable.
    ws2812b_pixel_bank #(.MAX_POS(MAX_POS)) uBank0 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .we_i    (writeAccept && bankSel_q),
        .waddr_i (wr_addr_i),
        .wdata_i (wrPixel),
        .raddr_i (program_led_number_i),
        .rdata_o (bank0Rd)
    );

    ws2812b_pixel_bank #(.MAX_POS(MAX_POS)) uBank1 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .we_i    (writeAccept && !bankSel_q),
        .waddr_i (wr_addr_i),
        .wdata_i (wrPixel),
        .raddr_i (program_led_number_i),
        .rdata_o (bank1Rd)
    );

    assign frontRd = bankSel_q ? bank1Rd : bank0Rd;

    assign program_green_intensity_o = frontRd[G_LSB +: CHAN_W];
    assign program_red_intensity_o   = frontRd[R_LSB +: CHAN_W];
    assign program_blue_intensity_o  = frontRd[B_LSB +: CHAN_W];

    assign wrap = (prevLed_q == LAST_POS) && (program_led_number_i == '0);

    // The refresh counter saturates so an overdue refresh fires on the first idle cycle.
    always_comb begin
        state_d         = state_q;
        bankSel_d       = bankSel_q;
        commitPending_d = commitPending_q || commit_i;
        updateFrame_d   = updateFrame_q;
        frameDone_d     = 1'b0;
        frameError_d    = 1'b0;
        refreshCnt_d    = (refreshCnt_q == REFRESH_LAST) ? refreshCnt_q : refreshCnt_q + 1'b1;
        wdCnt_d         = wdCnt_q;
        latchCnt_d      = latchCnt_q;
        prevLed_d       = prevLed_q;

        case (state_q)
            ST_IDLE: begin
                if (commitPending_q || (REFRESH_EN && (refreshCnt_q == REFRESH_LAST))) begin
                    if (commitPending_q) begin
                        bankSel_d       = !bankSel_q;
                        commitPending_d = 1'b0;
                    end
                    updateFrame_d = 1'b1;
                    state_d       = ST_SENDING;
                    refreshCnt_d  = '0;
                    wdCnt_d       = '0;
                    prevLed_d     = '0;
                end
            end
            ST_SENDING: begin
                prevLed_d = program_led_number_i;
                wdCnt_d   = wdCnt_q + 1'b1;
                if (wrap || (wdCnt_q == WD_LAST)) begin
                    updateFrame_d = 1'b0;
                    frameError_d  = !wrap;
                    state_d       = ST_LATCH;
                    latchCnt_d    = '0;
                end
            end
            ST_LATCH: begin
                latchCnt_d = latchCnt_q + 1'b1;
                if (latchCnt_q == LATCH_LAST) begin
                    frameDone_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                updateFrame_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= ST_IDLE;
            bankSel_q       <= 1'b0;
            commitPending_q <= 1'b0;
            updateFrame_q   <= 1'b0;
            frameDone_q     <= 1'b0;
            frameError_q    <= 1'b0;
            refreshCnt_q    <= '0;
            wdCnt_q         <= '0;
            latchCnt_q      <= '0;
            prevLed_q       <= '0;
        end else begin
            state_q         <= state_d;
            bankSel_q       <= bankSel_d;
            commitPending_q <= commitPending_d;
            updateFrame_q   <= updateFrame_d;
            frameDone_q     <= frameDone_d;
            frameError_q    <= frameError_d;
            refreshCnt_q    <= refreshCnt_d;
            wdCnt_q         <= wdCnt_d;
            latchCnt_q      <= latchCnt_d;
            prevLed_q       <= prevLed_d;
        end
    end

endmodule

// File: tb/tb_ws2812b_frame_buffer.sv
// Randomized bench for ws2812b_frame_buffer against a two-array pixel model with frame timing
// computed from the LED count, latch gap, refresh period and watchdog limit.
module tb_ws2812b_frame_buffer;

    localparam int MP  = 12;
    localparam int REF = 100;
    localparam int LAT = 20;
    localparam int TO  = 60;
    localparam int AW  = $clog2(MP);

    logic          clk = 1'b0;
    logic          reset;
    logic          wrValid, wrReady, commit, commitPending, updateFrame, frameDone, frameError;
    logic [AW-1:0] wrAddr, progLed;
    logic [7:0]    wrRed, wrGreen, wrBlue, progRed, progGreen, progBlue;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int riseCyc    = 0;

    // Model pixels are kept as {red, green, blue}.
    logic [23:0] frontMem [MP];
    logic [23:0] backMem  [MP];
    bit          pendingM;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ws2812b_frame_buffer #(
        .MAX_POS(MP), .REFRESH_CLKS(REF), .LATCH_CLKS(LAT), .SEND_TIMEOUT(TO)
    ) dut (
        .clk_i                     (clk),
        .reset_i                   (reset),
        .wr_valid_i                (wrValid),
        .wr_ready_o                (wrReady),
        .wr_addr_i                 (wrAddr),
        .wr_red_i                  (wrRed),
        .wr_green_i                (wrGreen),
        .wr_blue_i                 (wrBlue),
        .commit_i                  (commit),
        .commit_pending_o          (commitPending),
        .update_frame_o            (updateFrame),
        .program_led_number_i      (progLed),
        .program_red_intensity_o   (progRed),
        .program_green_intensity_o (progGreen),
        .program_blue_intensity_o  (progBlue),
        .frame_done_o              (frameDone),
        .frame_error_o             (frameError)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", tag, actual, expected, cyc);
        end
    endtask

    task automatic checkPixel(input string tag, input logic [AW-1:0] idx);
        logic [23:0] expected;
        expected = 24'h0;
        if (int'(idx) < MP) expected = frontMem[idx];
        checkOutput(tag, {8'h0, progRed, progGreen, progBlue}, {8'h0, expected});
    endtask

    task automatic clearModel();
        for (int i = 0; i < MP; i++) begin
            frontMem[i] = 24'h0;
            backMem[i]  = 24'h0;
        end
        pendingM = 1'b0;
    endtask

    task automatic swapModel();
        logic [23:0] tmp;
        for (int i = 0; i < MP; i++) begin
            tmp         = frontMem[i];
            frontMem[i] = backMem[i];
            backMem[i]  = tmp;
        end
        pendingM = 1'b0;
    endtask

    // Drives one cycle of host inputs from a negedge and advances the model at the posedge.
    task automatic applyStimulus(input bit v, input logic [AW-1:0] a, input logic [23:0] rgb, input bit c);
        wrValid = v;
        wrAddr  = a;
        {wrRed, wrGreen, wrBlue} = rgb;
        commit  = c;
        checkOutput("wr_ready", {31'h0, wrReady}, {31'h0, !pendingM});
        @(posedge clk);
        if (v && !pendingM && int'(a) < MP) backMem[a] = rgb;
        if (c) pendingM = 1'b1;
        @(negedge clk);
        wrValid = 1'b0;
        commit  = 1'b0;
    endtask

    task automatic randomWrite();
        applyStimulus(1'($urandom_range(1)), AW'($urandom_range((1 << AW) - 1)), 24'($urandom()), 1'b0);
    endtask

    task automatic commitFromIdle(input bit withWrite, input logic [AW-1:0] readIdx);
        applyStimulus(withWrite, AW'($urandom_range((1 << AW) - 1)), 24'($urandom()), 1'b1);
        checkOutput("pend_set", {31'h0, commitPending}, 32'd1);
        checkOutput("rdy_low", {31'h0, wrReady}, 32'd0);
        checkOutput("upd_wait", {31'h0, updateFrame}, 32'd0);
        applyStimulus(1'b0, '0, 24'h0, 1'b0);
        swapModel();
        riseCyc = cyc;
        checkOutput("upd_rise", {31'h0, updateFrame}, 32'd1);
        checkOutput("pend_clr", {31'h0, commitPending}, 32'd0);
        progLed = readIdx;
        #1;
        checkPixel("new_front", readIdx);
    endtask

    task automatic waitLatch();
        int k;
        k = 0;
        do begin
            randomWrite();
            k++;
            checkOutput("err_low", {31'h0, frameError}, 32'd0);
        end while (frameDone !== 1'b1 && k < 4 * LAT);
        checkOutput("latch_len", k, LAT);
    endtask

    // Acts as the driver: sweeps 0..MP-1 then 0, with host traffic riding along.
    task automatic runFrame(input int commitAt);
        logic [AW-1:0] idx;
        for (int j = 0; j <= MP; j++) begin
            idx = (j == MP) ? '0 : AW'(j);
            progLed = idx;
            #1;
            checkPixel("sweep_px", idx);
            applyStimulus(1'($urandom_range(1)), AW'($urandom_range((1 << AW) - 1)),
                          24'($urandom()), j == commitAt);
            if (j < MP) checkOutput("upd_hold", {31'h0, updateFrame}, 32'd1);
            else        checkOutput("upd_fall", {31'h0, updateFrame}, 32'd0);
        end
        waitLatch();
    endtask

    task automatic afterLatch(output bit swapped);
        swapped = pendingM;
        if (pendingM) begin
            checkOutput("late_pend", {31'h0, commitPending}, 32'd1);
            checkOutput("late_upd", {31'h0, updateFrame}, 32'd0);
            applyStimulus(1'b1, AW'($urandom_range(MP - 1)), 24'($urandom()), 1'b1);
            swapModel();
            riseCyc = cyc;
            checkOutput("late_rise", {31'h0, updateFrame}, 32'd1);
            checkOutput("late_pclr", {31'h0, commitPending}, 32'd0);
        end else begin
            applyStimulus(1'b0, '0, 24'h0, 1'b0);
            checkOutput("idle_upd", {31'h0, updateFrame}, 32'd0);
        end
        checkOutput("done_pulse", {31'h0, frameDone}, 32'd0);
    endtask

    task automatic waitRefresh();
        int k;
        k = 0;
        while (updateFrame !== 1'b1 && k < 3 * REF) begin
            applyStimulus(1'b0, '0, 24'h0, 1'b0);
            k++;
        end
        checkOutput("refresh_period", cyc - riseCyc, REF);
        riseCyc = cyc;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish before limit");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int  k;
        bit  swapped;
        reset   = 1'b1;
        wrValid = 1'b0;
        commit  = 1'b0;
        wrAddr  = '0;
        {wrRed, wrGreen, wrBlue} = 24'h0;
        progLed = '0;
        clearModel();
        repeat (3) @(negedge clk);
        checkOutput("rst_upd_in", {31'h0, updateFrame}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        progLed = AW'(5);
        #1;
        checkPixel("rst_px5", AW'(5));
        checkOutput("rst_rdy", {31'h0, wrReady}, 32'd1);
        checkOutput("rst_pend", {31'h0, commitPending}, 32'd0);
        checkOutput("rst_done", {31'h0, frameDone}, 32'd0);
        checkOutput("rst_err", {31'h0, frameError}, 32'd0);

        for (int it = 0; it < 6; it++) begin
            int nW;
            int commitAt;
            nW = $urandom_range(6, 2);
            for (int w = 0; w < nW; w++) randomWrite();
            if (it == 0) applyStimulus(1'b1, AW'(3), 24'h123456, 1'b0);
            for (int r = 0; r < 3; r++) begin
                progLed = AW'($urandom_range((1 << AW) - 1));
                #1;
                checkPixel("idle_px", progLed);
            end
            commitFromIdle(it != 0 && $urandom_range(1) == 1,
                           (it == 0) ? AW'(3) : AW'($urandom_range(MP - 1)));
            commitAt = ($urandom_range(1) == 1) ? int'($urandom_range(MP)) : -1;
            runFrame(commitAt);
            afterLatch(swapped);
            if (swapped) begin
                runFrame(-1);
                afterLatch(swapped);
            end
        end

        for (int r = 0; r < 2; r++) begin
            waitRefresh();
            runFrame(-1);
            afterLatch(swapped);
        end

        commitFromIdle(1'b1, AW'($urandom_range(MP - 1)));
        progLed = AW'(7);
        k = 0;
        do begin
            applyStimulus(1'b0, '0, 24'h0, 1'b0);
            k++;
        end while (updateFrame === 1'b1 && k < 2 * TO);
        checkOutput("timeout_len", k, TO);
        checkOutput("err_pulse", {31'h0, frameError}, 32'd1);
        waitLatch();
        afterLatch(swapped);
        commitFromIdle(1'b0, AW'($urandom_range(MP - 1)));
        runFrame(-1);
        afterLatch(swapped);

        commitFromIdle(1'b0, AW'($urandom_range(MP - 1)));
        for (int j = 0; j < 3; j++) begin
            progLed = AW'(j);
            applyStimulus(1'b0, '0, 24'h0, 1'b0);
        end
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_mid_upd", {31'h0, updateFrame}, 32'd0);
        checkOutput("rst_mid_pend", {31'h0, commitPending}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        clearModel();
        for (int j = 0; j < 4; j++) begin
            progLed = AW'($urandom_range((1 << AW) - 1));
            #1;
            checkPixel("rst_mid_px", progLed);
        end
        checkOutput("rst_mid_rdy", {31'h0, wrReady}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
